// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, REQ, WAIT, HOLD, HALTED)
//   ADDR_W_DEF    : default program counter / memory address width
//   HALT_OP       : opcode that stops fetch when FETCH_HALT_EN is defined
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam logic [3:0]  HALT_OP    = 4'hF;

endpackage

// File: rtl/instr_fetch_program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Program counter register with synchronous reset, global step enable,
// parallel load (jump) and increment with natural wrap at 2^ADDR_W.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset (pc -> 0)
//   enable        : global step enable; low holds pc
//   load          : load load_addr (takes priority over inc)
//   inc           : advance pc by one, wrapping to 0
//   load_addr     : jump target
//   pc            : current program counter
// ---------------------------------------------------------------------------
module program_counter #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= '0;
        end else if (enable) begin
            if (load) begin
                pc <= load_addr;
            end else if (inc) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: owns the program counter, reads one instruction
// byte per fetch from a synchronous RAM and presents it to the control unit
// through a valid/ready handshake. Jumps are taken on the accepting
// handshake.
// Optional feature macro: FETCH_HALT_EN -- opcode HALT_OP stops fetch after
// it has been accepted; only reset restarts. Undefined: HALT_OP is ordinary
// and halted is tied low.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   enable        : global step enable; low freezes all state
//   mem_addr      : RAM read address (equals pc, held through the read)
//   mem_rd        : RAM read strobe, one cycle per fetch
//   mem_data      : RAM read data, valid MEM_LAT cycles after mem_rd
//   instr         : captured instruction byte
//   opcode        : instr[7:4]
//   operando      : instr[3:0]
//   instr_valid   : instr holds an unconsumed instruction
//   instr_ready   : control unit accepts instr this cycle
//   jump          : take jump on the accepting handshake
//   jump_addr     : jump target
//   pc            : address of instruction held or being fetched
//   halted        : fetch stopped on halt opcode
// Parameters: ADDR_W (address width), MEM_LAT (RAM read latency, 1..3)
// ---------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic [7:0]        instr,
    output logic [3:0]        opcode,
    output logic [3:0]        operando,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

    fetch_state_t state, state_next;
    logic [1:0]   lat_cnt;
    logic         handshake;
    logic         is_halt;
    logic         capture;
    logic         pc_load;
    logic         pc_inc;

    assign handshake = enable && (state == HOLD) && instr_ready;
    // Capture on the edge where the latency counter reaches zero.
    assign capture   = enable && (state == WAIT) && (lat_cnt == 2'd1);

`ifdef FETCH_HALT_EN
    assign is_halt = (instr[7:4] == HALT_OP);
    assign halted  = (state == HALTED);
`else
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    // A halting handshake neither jumps nor advances: pc stays frozen.
    assign pc_load = handshake && !is_halt && jump;
    assign pc_inc  = handshake && !is_halt && !jump;

    program_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_addr (jump_addr),
        .pc        (pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                mem_rd     = enable;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 2'd1) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    state_next = is_halt ? HALTED : REQ;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (enable) begin
            if (state == REQ) begin
                lat_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            instr <= '0;
        end else if (capture) begin
            instr <= mem_data;
        end
    end

    // pc only changes on a handshake, so it is stable from REQ to capture.
    assign mem_addr    = pc;
    assign opcode      = instr[7:4];
    assign operando    = instr[3:0];
    assign instr_valid = (state == HOLD);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int unsigned MEM_LAT = 1;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic [7:0] instr;
    logic [3:0] opcode;
    logic [3:0] operando;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump;
    logic [3:0] jump_addr;
    logic [3:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .ADDR_W  (4),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .instr       (instr),
        .opcode      (opcode),
        .operando    (operando),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    // Synchronous RAM; 8'hEE appears when no read was issued.
    logic [7:0] ram [16];
    logic [7:0] rd_pipe [MEM_LAT];
    always @(posedge clock) begin
        rd_pipe[0] <= mem_rd ? ram[mem_addr] : 8'hEE;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data = rd_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: m_age counts cycles into a fetch
    // (-2 idle after reset, -1 no fetch in flight, 0 = read-request cycle).
    logic [3:0] m_pc;
    logic [7:0] m_instr;
    logic       m_valid;
    logic       m_halted;
    int         m_age;
    bit         m_ok = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_pc = '0; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0;
            m_age = -2; m_ok = 1'b1;
        end else if (enable && m_ok) begin
            if (m_valid && instr_ready) begin
                m_valid = 1'b0;
                if (HALT_EN && m_instr[7:4] == 4'hF) begin
                    m_halted = 1'b1;
                end else begin
                    m_pc  = jump ? jump_addr : m_pc + 4'd1;
                    m_age = 0;
                end
            end else if (m_age == -2) begin
                m_age = 0;
            end else if (m_age >= 0) begin
                if (m_age == int'(MEM_LAT)) begin
                    m_instr = ram[m_pc];
                    m_valid = 1'b1;
                    m_age   = -1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_ok) begin
            chk("valid",    32'(instr_valid), 32'(m_valid));
            chk("pc",       32'(pc),          32'(m_pc));
            chk("halted",   32'(halted),      32'(m_halted));
            chk("mem_rd",   32'(mem_rd),      32'((m_age == 0) && enable));
            chk("instr",    32'(instr),       32'(m_instr));
            chk("opcode",   32'(opcode),      32'(m_instr[7:4]));
            chk("operando", 32'(operando),    32'(m_instr[3:0]));
            if (m_age >= 0) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        end
    end

    // Bounded waits; each is entered just after a posedge and returns at a negedge.
    task automatic wait_rd(input string tag);
        int n = 0;
        @(negedge clock);
        while (!mem_rd && n < 40) begin @(negedge clock); n++; end
        if (!mem_rd) chk({"timeout_rd_", tag}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clock);
        while (!instr_valid && n < 40) begin @(negedge clock); n++; end
        if (!instr_valid) chk({"timeout_valid_", tag}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
    endtask

    int        hs_cyc [3];
    logic [7:0] hs_ins [3];
    logic [3:0] hs_pc  [3];
    int        nhs;
    bit        found;

    initial begin
        reset = 1'b1; enable = 1'b1; instr_ready = 1'b1; jump = 1'b0; jump_addr = '0;
        for (int i = 0; i < 15; i++) ram[i] = 8'(i * 16 + i);
        ram[15] = 8'h7E;
        ram[0]  = 8'h3A;

        // First fetch after reset release
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock); chk("t1_idle_rd", 32'(mem_rd), 32'd0);
        chk("t1_idle_valid", 32'(instr_valid), 32'd0);
        @(negedge clock); chk("t1_req_rd", 32'(mem_rd), 32'd1);
        chk("t1_req_addr", 32'(mem_addr), 32'd0);
        @(negedge clock); chk("t1_wait_valid", 32'(instr_valid), 32'd0);
        @(negedge clock); chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", 32'(instr), 32'h3A);
        chk("t1_opcode", 32'(opcode), 32'h3);
        chk("t1_operando", 32'(operando), 32'hA);
        chk("t1_pc", 32'(pc), 32'd0);

        // Sequential run, throughput
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
        do_reset();
        nhs = 0;
        for (int c = 0; c < 30 && nhs < 3; c++) begin
            @(negedge clock);
            if (instr_valid && instr_ready) begin
                hs_cyc[nhs] = c; hs_ins[nhs] = instr; hs_pc[nhs] = pc; nhs++;
            end
        end
        chk("t2_nhs", 32'(nhs), 32'd3);
        if (nhs == 3) begin
            chk("t2_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
            chk("t2_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
            chk("t2_ins0", 32'(hs_ins[0]), 32'h11);
            chk("t2_ins1", 32'(hs_ins[1]), 32'h22);
            chk("t2_ins2", 32'(hs_ins[2]), 32'h33);
            chk("t2_pc0", 32'(hs_pc[0]), 32'd0);
            chk("t2_pc1", 32'(hs_pc[1]), 32'd1);
            chk("t2_pc2", 32'(hs_pc[2]), 32'd2);
        end

        // Backpressure
        @(posedge clock); #1 instr_ready = 1'b0;
        wait_valid("t3");
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); @(negedge clock);
            chk("t3_instr", 32'(instr), 32'h44);
            chk("t3_rd", 32'(mem_rd), 32'd0);
            chk("t3_pc", 32'(pc), 32'd3);
        end
        // enable low: ready ignored, everything frozen
        @(posedge clock); #1 enable = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t3_en_pc", 32'(pc), 32'd3);
            chk("t3_en_valid", 32'(instr_valid), 32'd1);
            @(posedge clock); #1;
        end
        enable = 1'b1;
        wait_rd("t3");
        chk("t3_next_addr", 32'(mem_addr), 32'd4);

        // Wrap and jump
        @(posedge clock); #1 jump = 1'b1; jump_addr = 4'd15;
        do_reset();
        wait_valid("t4a");
        @(posedge clock); #1 jump = 1'b0;
        wait_rd("t4a"); chk("t4_addr15", 32'(mem_addr), 32'd15);
        wait_valid("t4b");
        chk("t4_pc15", 32'(pc), 32'd15);
        chk("t4_instr15", 32'(instr), 32'h7E);
        @(posedge clock); #1;
        wait_rd("t4b"); chk("t4_wrap_addr", 32'(mem_addr), 32'd0);
        @(posedge clock); #1 jump = 1'b1; jump_addr = 4'd7;
        wait_valid("t4c");
        @(posedge clock); #1 jump = 1'b0;
        wait_rd("t4c"); chk("t4_jump_addr", 32'(mem_addr), 32'd7);

        // Reset during WAIT discards the in-flight read
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("t5_valid", 32'(instr_valid), 32'd0);
        chk("t5_pc", 32'(pc), 32'd0);
        chk("t5_instr", 32'(instr), 32'h00);
        @(negedge clock);
        chk("t5_late", 32'(instr), 32'h00);

        // Halt opcode
        ram[2] = 8'hF0;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clock);
            if (instr_valid && instr_ready && instr == 8'hF0) found = 1'b1;
        end
        chk("t6_f0_seen", 32'(found), 32'd1);
        @(posedge clock); #1;
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("t6_halted", 32'(halted), 32'd1);
            chk("t6_valid", 32'(instr_valid), 32'd0);
            chk("t6_rd", 32'(mem_rd), 32'd0);
            chk("t6_pc", 32'(pc), 32'd2);
        end
`else
        wait_rd("t6");
        chk("t6_cont_addr", 32'(mem_addr), 32'd3);
        chk("t6_not_halted", 32'(halted), 32'd0);
`endif

        @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
